// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity mode encodings and the
// data-width clamp used when a word is accepted.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Zero or oversize requests fall back to the widest supported word.
  function automatic logic [5:0] clamp_bits(input logic [5:0] bits, input int unsigned max_w);
    if (bits == 6'd0 || 32'(bits) > max_w) return 6'(max_w);
    return bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load N (0 treated as 1) starts at N-1, tc_o marks
// the last cycle of the period. Also intended for the receiver side.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (val_i == '0) ? '0 : val_i - DIV_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, 1..MAX_WORD_SIZE data bits LSB first,
// optional parity, 1 or 2 stop bits, with ready/start handshake and done pulse.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int MAX_WORD_SIZE = 8,
  parameter int DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_WORD_SIZE-1:0] din,
  input  logic [5:0]               tx_bits,
  input  logic [DIV_W-1:0]         clks_per_bit,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  input  logic                     tx_start,
  output logic                     tx_ready,
  output logic                     tx_done,
  output logic                     tx
);

  localparam int IW = $clog2(MAX_WORD_SIZE + 1);
  // Shadow padded to a power of two so idx can index it at full width.
  localparam int SW = 2 ** IW;

  tx_state_e        state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [SW-1:0]    shadow_q, shadow_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             par_q, par_d;
  logic             par_en_q, par_en_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             tmr_load, tmr_tc;
  logic [DIV_W-1:0] tmr_val;

  // Accepting frame loads straight from the input; later bits reuse the latch.
  assign tmr_val = (state_q == IDLE) ? clks_per_bit : div_q;

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    shadow_d = shadow_q;
    div_d    = div_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shadow_d = SW'(din);
          last_d   = IW'(clamp_bits(tx_bits, MAX_WORD_SIZE) - 6'd1);
          div_d    = clks_per_bit;
          par_en_d = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          // Odd parity is the even XOR seeded with 1.
          par_d    = (parity_mode == PAR_ODD);
          stop2_d  = two_stop;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          par_d    = par_q ^ shadow_q[idx_q];
          if (idx_q == last_q) state_d = par_en_q ? PARITY : STOP;
          else                 idx_d   = idx_q + IW'(1);
        end
      end
      PARITY: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (tmr_tc) begin
          if (stop2_q) begin
            stop2_d  = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered, so tx stays registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shadow_d[idx_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      shadow_q <= '0;
      div_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_done  = done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: driver pushes the expected line levels of
// every accepted frame, an independent monitor checks the serial pin cycle by cycle.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic [5:0]  tx_bits = '0;
  logic [15:0] clks_per_bit = '0;
  logic [1:0]  parity_mode = '0;
  logic        two_stop = 1'b0;
  logic        tx_start = 1'b0;
  logic        tx_ready, tx_done, tx;

  int vectors = 0;
  int miscompares = 0;
  int frame_id = 0;

  typedef struct {
    int          n;
    int          len;
    logic [15:0] lv;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_frame #(.MAX_WORD_SIZE(8), .DIV_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .tx_bits      (tx_bits),
    .clks_per_bit (clks_per_bit),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .tx_start     (tx_start),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Frame as a list of line levels, one per bit period.
  function automatic exp_t model(input logic [7:0] d, input int b, input int n,
                                 input int pm, input bit two);
    exp_t e;
    int   ones;
    e.lv   = '1;
    e.n    = (n == 0) ? 1 : n;
    if (b == 0 || b > 8) b = 8;
    e.lv[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < b; i++) begin
      e.lv[1 + i] = (d >> i) & 1;
      ones += (d >> i) & 1;
    end
    e.len = 1 + b;
    if (pm == 1 || pm == 2) begin
      e.lv[e.len] = ((ones % 2) == 1) ^ (pm == 2);
      e.len++;
    end
    e.lv[e.len] = 1'b1;
    e.len += two ? 2 : 1;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!tx_ready && w < 1000) begin step(); w++; end
    if (!tx_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [7:0] d, input int b, input int n, input int pm, input bit two);
    wait_ready("send");
    din          = d;
    tx_bits      = 6'(b);
    clks_per_bit = 16'(n);
    parity_mode  = 2'(pm);
    two_stop     = two;
    tx_start     = 1'b1;
    exp_q.push_back(model(d, b, n, pm, two));
    step();
    tx_start = 1'b0;
  endtask

  // Monitor: a ready->busy transition marks an accepted frame.
  initial begin : monitor
    exp_t e;
    bit   prev_ready = 1'b1;
    bit   aborted;
    int   highs;
    int   ctl_bad;
    forever begin
      @(negedge clk);
      if (rst) begin prev_ready = 1'b1; continue; end
      if (prev_ready && !tx_ready) begin
        frame_id++;
        if (exp_q.size() == 0) begin
          chk("extra_frame", 1, 0);
          prev_ready = 1'b0;
          continue;
        end
        e = exp_q.pop_front();
        aborted = 1'b0;
        ctl_bad = 0;
        for (int j = 0; j < e.len && !aborted; j++) begin
          highs = 0;
          for (int c = 0; c < e.n; c++) begin
            if (j != 0 || c != 0) @(negedge clk);
            if (rst) begin aborted = 1'b1; break; end
            highs += (tx === 1'b1) ? 1 : 0;
            if (tx_ready !== 1'b0 || tx_done !== 1'b0) ctl_bad++;
          end
          if (!aborted)
            chk($sformatf("frame%0d_bit%0d_highcycles", frame_id, j), highs, e.lv[j] ? e.n : 0);
        end
        if (aborted) begin
          @(negedge clk);
          chk("post_reset_line", {29'd0, tx, tx_ready, tx_done}, 3'b110);
          prev_ready = 1'b1;
          continue;
        end
        chk($sformatf("frame%0d_busy_ctl", frame_id), ctl_bad, 0);
        @(negedge clk);
        chk($sformatf("frame%0d_end", frame_id), {29'd0, tx, tx_ready, tx_done}, 3'b111);
        prev_ready = tx_ready;
        continue;
      end
      if (tx_ready) begin
        if (tx !== 1'b1 || tx_done !== 1'b0) chk("idle_line", {30'd0, tx, tx_done}, 2'b10);
      end else if (!prev_ready) begin
        chk("unexpected_busy", 1, 0);
      end
      prev_ready = tx_ready;
    end
  end

  initial begin : driver
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_state", {29'd0, tx, tx_ready, tx_done}, 3'b110);

    send(8'hA5, 8, 4, 0, 1'b0);
    send(8'h87, 7, 1, 1, 1'b0);
    send(8'h87, 7, 1, 2, 1'b0);
    send(8'h3C, 0, 0, 0, 1'b0);
    send(8'hC3, 9, 0, 1, 1'b0);

    // Held tx_start: frames must run back to back with one ready cycle between.
    wait_ready("b2b");
    din = 8'h5A; tx_bits = 6'd8; clks_per_bit = 16'd3; parity_mode = 2'd2; two_stop = 1'b1;
    tx_start = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_ready("b2b_loop");
      if (f > 0) chk("b2b_done_pulse", int'(tx_done), 1);
      exp_q.push_back(model(8'h5A, 8, 3, 2, 1'b1));
      step();
      chk("b2b_busy_after_accept", int'(tx_ready), 0);
    end
    tx_start = 1'b0;

    // Reset in the middle of data bit 3 (frame bit 4, cycles 17..20 with N=4).
    send(8'hFF, 8, 4, 1, 1'b0);
    repeat (17) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(8'h96, 8, 2, 1, 1'b1);

    // Config churn and busy-time start pulses must not disturb the frame.
    send(8'h1E, 8, 3, 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (!tx_ready) begin
        din          = 8'($urandom);
        parity_mode  = 2'($urandom);
        tx_bits      = 6'($urandom);
        clks_per_bit = 16'($urandom_range(0, 7));
        two_stop     = 1'($urandom);
        tx_start     = 1'($urandom);
      end else begin
        tx_start = 1'b0;
      end
      step();
    end
    tx_start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      wait_ready("rand");
      if (gap > 1) repeat (gap) step();
      send(8'($urandom), $urandom_range(0, 10), $urandom_range(0, 4),
           $urandom_range(0, 3), 1'($urandom));
    end

    wait_ready("final");
    repeat (4) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one word per handshake into a complete asynchronous frame: start bit, 1..MAX_WORD_SIZE data bits LSB first, optional even/odd parity, and 1 or 2 stop bits. A run-time clock divider sets the bit period. It sits between the correlator result path and the serial pin, and adds a ready/start handshake and frame-complete pulse so words can be streamed back to back without gaps.

## Interface
- MAX_WORD_SIZE, 8, widest data word; `din` width.
- DIV_W, 16, width of the bit-period divider input.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  MAX_WORD_SIZE  word to send; sampled only on accept.
- tx_bits  in  6  data bits per frame; 0 or >MAX_WORD_SIZE clamps to MAX_WORD_SIZE; sampled on accept.
- clks_per_bit  in  DIV_W  clk cycles per serial bit; 0 treated as 1; sampled on accept.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none; sampled on accept.
- two_stop  in  1  1 = two stop bits; sampled on accept.
- tx_start  in  1  request; accepted when `tx_start & tx_ready`.
- tx_ready  out  1  high exactly when state is IDLE.
- tx_done  out  1  one-cycle pulse when a frame's last stop bit ends.
- tx  out  1  serial line, idle high, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. On accept, latch din, clamped tx_bits (B), divider (N), parity mode, stop count (S = 1 or 2). Clear the bit index, load the bit timer, and go to START.
- START: tx=0 for N cycles, then DATA.
- DATA: tx=shadow[idx] for N cycles per bit, idx 0..B-1. After bit B-1, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: tx = XOR of the B sent bits (even), or its inverse (odd), for N cycles.
- STOP: tx=1 for S·N cycles, then IDLE with tx_done pulsed.
- Data bits above B-1 are never sent and do not enter the parity calculation.
- Changes on din or the config inputs mid-frame have no effect.
- tx_start while busy is ignored and not queued.
- Reset (any state, including mid-frame): state=IDLE, tx=1, tx_done=0, tx_ready=1, bit timer and idx cleared. tx_start is ignored while rst=1. A frame cut short by reset is not resumed.

## Timing
- Accept at rising edge k → tx=0 from cycle k+1.
- Frame length is exactly N·(1+B+P+S) cycles, where P = 1 if parity is enabled, else 0.
- Bit j of the frame (start = bit 0) occupies cycles k+1+N·j through k+N·(j+1).
- The cycle after the last stop cycle: state is IDLE, tx_ready=1, tx_done=1 for that one cycle.
- Back-to-back: if tx_start is high in that cycle, the next start bit begins on the following cycle, so there are no idle-high gaps beyond the stop bits.
- Bit timer counts N-1 down to 0. The bit advances at terminal count. Counter width is DIV_W and never wraps within a bit.
- Idx width is clog2(MAX_WORD_SIZE+1). Comparison is against B-1 with B ≥ 1 guaranteed by the clamp.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - clamp function for tx_bits.
- One sub-module, `uart_bit_timer`:
  - DIV_W down-counter with load (value N, zero→1) and a terminal-count output;
  - reused later by the receiver.
- FSM, shadow register, parity accumulator and idx stay in the top module.

## Test plan
- N=4, B=8, no parity, 1 stop, din=0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. 40-cycle frame. tx_done pulses at cycle k+41.
- N=1, B=7, even parity, din=0x07 (three ones) → parity bit 1. With odd parity, parity bit 0. Frame 10 cycles. din bit 7 is never driven on tx.
- tx_bits=0 and tx_bits=9 with MAX_WORD_SIZE=8 → both send 8 data bits. clks_per_bit=0 behaves as 1.
- two_stop=1, N=3 → stop high for 6 cycles. tx_start held continuously → second start bit immediately after, tx_ready high only one cycle between frames.
- Assert rst during DATA bit 3 → next cycle tx=1, tx_ready=1, no tx_done. New accept sends a full fresh frame.
- Toggle din and parity_mode mid-frame, and pulse tx_start while busy → transmitted frame is unchanged and no extra frame is sent.
